// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Shared types and constants for the 5-stage core pipeline
//                control logic (hazard controller and its helpers).
//  Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

  localparam int          REG_ADDR_W = 5;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  // Sequencing states of the hazard controller
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2,
    MEM_ACK  = 2'd3
  } ctrl_state_e;

  // Width of a down-counter that must hold values 0..v; never narrower than 1
  function automatic int cnt_w(input int v);
    cnt_w = (v < 1) ? 1 : $clog2(v + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/loaduse_detect.sv
`default_nettype none
// ============================================================================
//  Module      : loaduse_detect
//  Description : Combinational load-use dependency check between the load in
//                EX and the source operands of the instruction in ID.
//                A load to x0 never creates a dependency.
//  Revision    : 1.0 - initial release
// ============================================================================
module loaduse_detect
  import core_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  output logic                  hazard
);

  // Flag ID operands that need the value still being loaded in EX
  always_comb begin
    hazard = ex_mem_read && (ex_rd != '0) &&
             ((id_use_rs1 && (id_rs1 == ex_rd)) ||
              (id_use_rs2 && (id_rs2 == ex_rd)));
  end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline sequencing controller. Produces fetch stall, IF/ID
//                flush, ID/EX bubble and EX/MEM freeze from load-use hazards,
//                taken branches resolved in EX and multi-cycle data-memory
//                accesses in MEM.
//                Optional macro HAZARD_CTRL_PERF_EN adds three saturating
//                32-bit performance counters as extra output ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int MEM_LATENCY  = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_take_branch,
  input  logic                  mem_req,
  output logic                  stall,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  ex_mem_stall,
  output logic                  mem_done
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0]           perf_stall_cycles,
  output logic [31:0]           perf_flushes,
  output logic [31:0]           perf_loaduse
`endif
);

  localparam int FLUSH_W = cnt_w(FLUSH_CYCLES);
  localparam int WAIT_W  = cnt_w(MEM_LATENCY);
  localparam bit MEM_EN  = (MEM_LATENCY > 0);

  localparam logic [FLUSH_W-1:0] FLUSH_INIT = FLUSH_W'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 1 : 0);
  localparam logic [WAIT_W-1:0]  WAIT_INIT  = WAIT_W'((MEM_LATENCY > 1) ? MEM_LATENCY - 1 : 0);

  ctrl_state_e        state_q, state_d;
  logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;

  logic lu_hazard;
  logic eval_run;      // branch / load-use evaluated this cycle as in RUN
  logic br_accept;     // a taken branch is acted on this cycle
  logic lu_accept;     // a load-use bubble is inserted this cycle

  loaduse_detect u_loaduse_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .hazard      (lu_hazard)
  );

  // Next-state and combinational outputs; a memory freeze pre-empts everything,
  // and a flush count interrupted by a freeze is kept and resumed after the ack.
  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    stall        = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_stall = 1'b0;
    mem_done     = 1'b0;
    eval_run     = 1'b0;
    br_accept    = 1'b0;
    lu_accept    = 1'b0;

    case (state_q)
      RUN, FLUSH: begin
        if (MEM_EN && mem_req) begin
          stall        = 1'b1;
          ex_mem_stall = 1'b1;
          if (WAIT_INIT == '0) begin
            state_d = MEM_ACK;
          end else begin
            state_d    = MEM_WAIT;
            wait_cnt_d = WAIT_INIT;
          end
        end else if (state_q == FLUSH) begin
          // ID holds a squashed instruction and EX is bubbled: only flush here
          if_id_flush = 1'b1;
          flush_cnt_d = flush_cnt_q - 1'b1;
          if (flush_cnt_q == FLUSH_W'(1)) begin
            state_d = RUN;
          end
        end else begin
          eval_run = 1'b1;
        end
      end
      MEM_WAIT: begin
        stall        = 1'b1;
        ex_mem_stall = 1'b1;
        if (wait_cnt_q <= WAIT_W'(1)) begin
          state_d    = MEM_ACK;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end
      MEM_ACK: begin
        mem_done = 1'b1;
        eval_run = 1'b1;
        state_d  = (flush_cnt_q != '0) ? FLUSH : RUN;
      end
      default: begin
        state_d     = RUN;
        flush_cnt_d = '0;
        wait_cnt_d  = '0;
      end
    endcase

    if (eval_run) begin
      if (ex_take_branch) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        br_accept    = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_d     = FLUSH;
          flush_cnt_d = FLUSH_INIT;
        end
      end else if (lu_hazard) begin
        stall        = 1'b1;
        id_ex_bubble = 1'b1;
        lu_accept    = 1'b1;
      end
    end

    // Without wait states the access completes in the request cycle
    if (!MEM_EN) begin
      mem_done = mem_req;
    end

    if (rst) begin
      stall        = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      ex_mem_stall = 1'b0;
      mem_done     = 1'b0;
      br_accept    = 1'b0;
      lu_accept    = 1'b0;
    end
  end

  // State and counter registers; reset abandons any wait or flush in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;
  logic [31:0] perf_lu_q,    perf_lu_d;

  // Saturating event counters
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    perf_lu_d    = perf_lu_q;
    if (stall && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + 32'd1;
    if (br_accept && (perf_flush_q != '1)) perf_flush_d = perf_flush_q + 32'd1;
    if (lu_accept && (perf_lu_q != '1)) perf_lu_d = perf_lu_q + 32'd1;
  end

  // Counter registers, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
      perf_lu_q    <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
      perf_lu_q    <= perf_lu_d;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flushes      = perf_flush_q;
  assign perf_loaduse      = perf_lu_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl (MEM_LATENCY=2,
//                FLUSH_CYCLES=2). Directed vectors push expected outputs into
//                a scoreboard queue; a monitor pops and compares each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_take_branch, mem_req;
  logic       stall, if_id_flush, id_ex_bubble, ex_mem_stall, mem_done;
`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] perf_stall_cycles, perf_flushes, perf_loaduse;
`endif

  int checks = 0;
  int errors = 0;

  // Expected vectors: {stall, if_id_flush, id_ex_bubble, ex_mem_stall, mem_done}
  localparam logic [4:0] E0   = 5'b00000;
  localparam logic [4:0] E_LU = 5'b10100;
  localparam logic [4:0] E_BR = 5'b01100;
  localparam logic [4:0] E_FL = 5'b01000;
  localparam logic [4:0] E_FZ = 5'b10010;
  localparam logic [4:0] E_DN = 5'b00001;
  localparam logic [4:0] E_DB = 5'b01101;

  typedef struct {
    logic       chk;
    logic [4:0] exp;
    string      name;
  } sb_item_t;

  sb_item_t sb[$];

  hazard_ctrl #(.MEM_LATENCY(2), .FLUSH_CYCLES(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .ex_rd          (ex_rd),
    .ex_mem_read    (ex_mem_read),
    .ex_take_branch (ex_take_branch),
    .mem_req        (mem_req),
    .stall          (stall),
    .if_id_flush    (if_id_flush),
    .id_ex_bubble   (id_ex_bubble),
    .ex_mem_stall   (ex_mem_stall),
    .mem_done       (mem_done)
`ifdef HAZARD_CTRL_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flushes      (perf_flushes),
    .perf_loaduse      (perf_loaduse)
`endif
  );

  always #5 clk = ~clk;

  // Monitor: one scoreboard entry per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_item_t e;
      logic [4:0] got;
      e   = sb.pop_front();
      got = {stall, if_id_flush, id_ex_bubble, ex_mem_stall, mem_done};
      if (e.chk) begin
        checks++;
        if (got !== e.exp) begin
          errors++;
          $display("FAIL %s: got %b expected %b (stall,flush,bubble,exmem,done)",
                   e.name, got, e.exp);
        end
      end
    end
  end

  // Drive one cycle of inputs and queue its expected outputs
  task automatic step(input string nm, input logic r,
                      input logic [4:0] s1, input logic [4:0] s2,
                      input logic u1, input logic u2,
                      input logic [4:0] rd, input logic ld,
                      input logic br, input logic mr,
                      input logic chk, input logic [4:0] exp);
    sb_item_t e;
    @(posedge clk);
    #1;
    rst = r; id_rs1 = s1; id_rs2 = s2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_rd = rd; ex_mem_read = ld; ex_take_branch = br; mem_req = mr;
    e.chk = chk; e.exp = exp; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic idle(input string nm, input logic [4:0] exp);
    step(nm, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, exp);
  endtask

  task automatic memreq(input string nm, input logic br, input logic [4:0] exp);
    step(nm, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, br, 1'b1, 1'b1, exp);
  endtask

  initial begin
    rst = 1'b1; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = '0; ex_mem_read = 1'b0; ex_take_branch = 1'b0; mem_req = 1'b0;

    // Reset state
    step("reset0", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, E0);
    step("reset1", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, E0);
    idle("post_reset", E0);

    // Load-use detection
    step("lu_rs2",    1'b0, 5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, E_LU);
    idle("lu_rs2_after", E0);
    step("lu_rs1",    1'b0, 5'd7, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, E_LU);
    step("lu_nouse",  1'b0, 5'd7, 5'd2, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, E0);
    step("lu_x0",     1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, E0);
    step("lu_noload", 1'b0, 5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, E0);

    // Branch in RUN: two flush cycles, one bubble, load-use ignored in FLUSH
    step("br_run",    1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, E_BR);
    step("br_flush",  1'b0, 5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, E_FL);
    idle("br_done", E0);

    // Held memory request: two freeze cycles then ack (request still held)
    memreq("mem_fz1", 1'b0, E_FZ);
    memreq("mem_fz2", 1'b0, E_FZ);
    memreq("mem_ack", 1'b0, E_DN);
    idle("mem_done_after", E0);

    // Branch together with memory request: branch taken in MEM_ACK
    memreq("brm_fz1", 1'b1, E_FZ);
    memreq("brm_fz2", 1'b1, E_FZ);
    step("brm_ack",   1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, E_DB);
    idle("brm_flush", E_FL);
    idle("brm_done", E0);

    // Memory request during FLUSH: flush count saved and resumed after ack
    step("fm_br",     1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, E_BR);
    memreq("fm_fz1", 1'b0, E_FZ);
    memreq("fm_fz2", 1'b0, E_FZ);
    idle("fm_ack", E_DN);
    idle("fm_resume", E_FL);
    idle("fm_done", E0);

    // Priority in RUN: mem_req over load-use, branch over load-use
    step("pri_mem_lu", 1'b0, 5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, E_FZ);
    memreq("pri_fz2", 1'b0, E_FZ);
    idle("pri_ack", E_DN);
    step("pri_br_lu",  1'b0, 5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, E_BR);
    idle("pri_flush", E_FL);
    idle("pri_done", E0);

    // Reset in the middle of MEM_WAIT
    memreq("rst_fz1", 1'b0, E_FZ);
    step("rst_mid",   1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E0);
    idle("rst_after", E0);
`ifdef HAZARD_CTRL_PERF_EN
    @(negedge clk);
    checks++;
    if ({perf_stall_cycles, perf_flushes, perf_loaduse} !== 96'd0) begin
      errors++;
      $display("FAIL perf_after_rst: got %0d/%0d/%0d expected 0/0/0",
               perf_stall_cycles, perf_flushes, perf_loaduse);
    end
`endif
    memreq("rst_new_fz1", 1'b0, E_FZ);
    memreq("rst_new_fz2", 1'b0, E_FZ);
    idle("rst_new_ack", E_DN);
    idle("rst_new_done", E0);

    // Drain the scoreboard with a bounded wait
    begin
      int budget = 20;
      while (sb.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      if (sb.size() > 0) begin
        errors++;
        $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
